// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared widths, NOP encoding and FSM state encoding for the fetch stage
package ifu_fetch_pkg;
  localparam int IFU_XLEN = 32;
  localparam logic [31:0] IFU_NOP_INST = 32'h0000_0013;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    DROP = 3'd4
  } state_e;
endpackage

// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch with decode handshake and redirect flush
// Optional misaligned-PC trap enabled by defining IFU_MISALIGN_CHK_EN.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int          XLEN     = IFU_XLEN,
  parameter logic [31:0] NOP_INST = IFU_NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_en,
  input  logic            flush,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_inst,
  output logic [XLEN-1:0] id_pc,
  output logic            id_misalign
);
  state_e      state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic        mis_q, mis_d;
  logic        mis_pc, fire;
`ifdef IFU_MISALIGN_CHK_EN
  assign mis_pc = |pc_in[1:0];
`else
  assign mis_pc = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      inst_q  <= NOP_INST;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      mis_q   <= mis_d;
    end
  end
  // flush takes priority over every handshake completing in the same cycle
  always_comb begin
    state_d        = state_q;
    inst_d         = inst_q;
    mis_d          = mis_q;
    imem_req_valid = 1'b0;
    id_valid       = 1'b0;
    fire           = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (mis_pc) begin
          state_d = flush ? REQ : HOLD;
          mis_d   = !flush;
          inst_d  = NOP_INST;
        end else begin
          imem_req_valid = 1'b1;
          state_d = imem_req_ready ? (flush ? DROP : WAIT) : REQ;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          state_d = flush ? REQ : HOLD;
          inst_d  = flush ? inst_q : imem_rsp_data;
        end else if (flush) begin
          state_d = DROP;
        end
      end
      HOLD: begin
        id_valid = !flush;
        fire     = !flush && id_ready;
        if (flush || id_ready) begin
          state_d = REQ;
          mis_d   = 1'b0;
        end
      end
      DROP: state_d = imem_rsp_valid ? REQ : DROP;
      default: state_d = IDLE;
    endcase
  end
  assign pc_en         = fire | flush;
  assign imem_req_addr = pc_in;
  assign id_pc         = pc_in;
  assign id_inst       = (state_q == HOLD) ? inst_q : NOP_INST;
  assign id_misalign   = mis_q;
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed self-checking bench for ifu_fetch
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_in = 32'h8000_0000;
  logic        pc_en, flush = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        id_valid, id_ready = 1'b0;
  logic [31:0] id_inst, id_pc;
  logic        id_misalign;
  int          tests = 0, fails = 0;
  logic        proto_err = 1'b0;

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_en(pc_en), .flush(flush),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .id_valid(id_valid), .id_ready(id_ready),
    .id_inst(id_inst), .id_pc(id_pc), .id_misalign(id_misalign)
  );

  // a response is only legal while a request is outstanding
  always @(negedge clk)
    if (!rst && imem_rsp_valid && !(dut.state_q inside {WAIT, DROP})) proto_err <= 1'b1;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({imem_req_valid, id_valid, pc_en, id_misalign} !== 4'b0000 || id_inst !== IFU_NOP_INST) begin
      fails++;
      $display("FAIL reset: req_v/id_v/pc_en/mis=%b%b%b%b inst=%h, want 0000 inst=%h",
               imem_req_valid, id_valid, pc_en, id_misalign, id_inst, IFU_NOP_INST);
    end
  endtask

  task automatic test_basic();
    nxt(); rst = 1'b0; imem_req_ready = 1'b1; id_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL idle_noreq: req_v=%b want 0", imem_req_valid); end
    nxt();
    @(negedge clk);
    tests++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
      fails++; $display("FAIL first_req: req_v=%b addr=%h want 1 80000000", imem_req_valid, imem_req_addr);
    end
    nxt(); imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0093;
    @(negedge clk);
    tests++;
    if ({imem_req_valid, id_valid, pc_en} !== 3'b000) begin
      fails++; $display("FAIL wait_quiet: req_v/id_v/pc_en=%b%b%b want 000", imem_req_valid, id_valid, pc_en);
    end
    nxt(); imem_rsp_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({id_valid, pc_en} !== 2'b11 || id_inst !== 32'h0000_0093 || id_pc !== 32'h8000_0000) begin
      fails++; $display("FAIL first_issue: id_v=%b pc_en=%b inst=%h pc=%h want 1 1 00000093 80000000",
                        id_valid, pc_en, id_inst, id_pc);
    end
    nxt(); pc_in = 32'h8000_0004;
    @(negedge clk);
    tests++;
    if ({pc_en, id_valid, imem_req_valid} !== 3'b001 || imem_req_addr !== 32'h8000_0004) begin
      fails++; $display("FAIL next_req: pc_en/id_v/req_v=%b%b%b addr=%h want 001 80000004",
                        pc_en, id_valid, imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      tests++;
      if ({imem_req_valid, pc_en} !== 2'b10 || imem_req_addr !== 32'h8000_0004) begin
        fails++; $display("FAIL stall_%0d: req_v=%b pc_en=%b addr=%h want 1 0 80000004",
                          i, imem_req_valid, pc_en, imem_req_addr);
      end
      nxt();
      @(negedge clk);
    end
    nxt(); imem_req_ready = 1'b1;
    nxt(); imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0093;
    @(negedge clk);
    tests++;
    if (pc_en !== 1'b0) begin fails++; $display("FAIL stall_no_pc_en: pc_en=%b want 0", pc_en); end
  endtask

  task automatic test_backpressure();
    nxt(); imem_rsp_valid = 1'b0; id_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if ({id_valid, imem_req_valid, pc_en} !== 3'b100 || id_inst !== 32'h0010_0093 || id_pc !== 32'h8000_0004) begin
        fails++; $display("FAIL bp_%0d: id_v/req_v/pc_en=%b%b%b inst=%h pc=%h want 100 00100093 80000004",
                          i, id_valid, imem_req_valid, pc_en, id_inst, id_pc);
      end
      nxt();
    end
    id_ready = 1'b1;
    @(negedge clk);
    tests++;
    if ({id_valid, pc_en} !== 2'b11) begin fails++; $display("FAIL bp_fire: id_v=%b pc_en=%b want 1 1", id_valid, pc_en); end
    nxt(); pc_in = 32'h8000_0008;
    @(negedge clk);
    tests++;
    if ({id_valid, pc_en, imem_req_valid} !== 3'b001 || imem_req_addr !== 32'h8000_0008) begin
      fails++; $display("FAIL bp_single: id_v/pc_en/req_v=%b%b%b addr=%h want 001 80000008",
                        id_valid, pc_en, imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_flush_wait();
    nxt(); imem_req_ready = 1'b1;
    nxt(); imem_req_ready = 1'b0; flush = 1'b1;
    @(negedge clk);
    tests++;
    if ({pc_en, id_valid} !== 2'b10) begin fails++; $display("FAIL fw_flush: pc_en=%b id_v=%b want 1 0", pc_en, id_valid); end
    nxt(); flush = 1'b0; pc_in = 32'h8000_0100;
    @(negedge clk);
    tests++;
    if ({imem_req_valid, id_valid, pc_en} !== 3'b000) begin
      fails++; $display("FAIL fw_drop: req_v/id_v/pc_en=%b%b%b want 000", imem_req_valid, id_valid, pc_en);
    end
    nxt(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    @(negedge clk);
    tests++;
    if ({imem_req_valid, id_valid} !== 2'b00) begin
      fails++; $display("FAIL fw_stale: req_v=%b id_v=%b want 0 0", imem_req_valid, id_valid);
    end
    nxt(); imem_rsp_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({imem_req_valid, id_valid} !== 2'b10 || imem_req_addr !== 32'h8000_0100) begin
      fails++; $display("FAIL fw_redirect: req_v=%b id_v=%b addr=%h want 1 0 80000100",
                        imem_req_valid, id_valid, imem_req_addr);
    end
  endtask

  task automatic test_flush_hold();
    nxt(); imem_req_ready = 1'b1;
    nxt(); imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0020_0093;
    nxt(); imem_rsp_valid = 1'b0; id_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    tests++;
    if ({id_valid, pc_en} !== 2'b01) begin fails++; $display("FAIL fh_nofire: id_v=%b pc_en=%b want 0 1", id_valid, pc_en); end
    nxt(); flush = 1'b0; pc_in = 32'h8000_0200;
    @(negedge clk);
    tests++;
    if ({id_valid, pc_en, imem_req_valid} !== 3'b001 || imem_req_addr !== 32'h8000_0200) begin
      fails++; $display("FAIL fh_next: id_v/pc_en/req_v=%b%b%b addr=%h want 001 80000200",
                        id_valid, pc_en, imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_flush_req_ready();
    nxt(); imem_req_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    tests++;
    if ({imem_req_valid, pc_en} !== 2'b11) begin fails++; $display("FAIL fr_accept: req_v=%b pc_en=%b want 1 1", imem_req_valid, pc_en); end
    nxt(); imem_req_ready = 1'b0; flush = 1'b0; pc_in = 32'h8000_0300;
    @(negedge clk);
    tests++;
    if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL fr_drop: req_v=%b want 0", imem_req_valid); end
    nxt(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1111_1111;
    @(negedge clk);
    tests++;
    if (id_valid !== 1'b0) begin fails++; $display("FAIL fr_discard: id_v=%b want 0", id_valid); end
    nxt(); imem_rsp_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0300) begin
      fails++; $display("FAIL fr_next: req_v=%b addr=%h want 1 80000300", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_misalign();
    nxt(); flush = 1'b1;
    @(negedge clk);
    tests++;
    if ({imem_req_valid, pc_en} !== 2'b11) begin fails++; $display("FAIL ma_flush_stall: req_v=%b pc_en=%b want 1 1", imem_req_valid, pc_en); end
    nxt(); flush = 1'b0; pc_in = 32'h8000_0002;
    @(negedge clk);
`ifdef IFU_MISALIGN_CHK_EN
    tests++;
    if ({imem_req_valid, id_valid} !== 2'b00) begin fails++; $display("FAIL ma_noreq: req_v=%b id_v=%b want 0 0", imem_req_valid, id_valid); end
    nxt();
    @(negedge clk);
    tests++;
    if ({imem_req_valid, id_valid, id_misalign, pc_en} !== 4'b0111 || id_inst !== 32'h0000_0013 || id_pc !== 32'h8000_0002) begin
      fails++; $display("FAIL ma_hold: req_v/id_v/mis/pc_en=%b%b%b%b inst=%h pc=%h want 0111 00000013 80000002",
                        imem_req_valid, id_valid, id_misalign, pc_en, id_inst, id_pc);
    end
    nxt(); pc_in = 32'h8000_0008;
    @(negedge clk);
    tests++;
    if ({id_misalign, imem_req_valid} !== 2'b01) begin fails++; $display("FAIL ma_clear: mis=%b req_v=%b want 0 1", id_misalign, imem_req_valid); end
`else
    tests++;
    if ({imem_req_valid, id_misalign} !== 2'b10 || imem_req_addr !== 32'h8000_0002) begin
      fails++; $display("FAIL ma_passthru: req_v=%b mis=%b addr=%h want 1 0 80000002",
                        imem_req_valid, id_misalign, imem_req_addr);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_backpressure();
    test_flush_wait();
    test_flush_hold();
    test_flush_req_ready();
    test_misalign();
    tests++;
    if (proto_err !== 1'b0) begin fails++; $display("FAIL rsp_protocol: response seen outside WAIT/DROP, got %b want 0", proto_err); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
